// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode/execute hazard inputs and pipeline-register control outputs
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_rs1_use_i;
    logic       id_rs2_use_i;
    logic [4:0] ex_rd_addr_i;
    logic       ex_rd_we_i;
    logic       ex_is_load_i;
    logic       ex_jump_i;
    logic       ex_mdiv_start_i;
    logic       mdiv_done_i;
    logic       pc_hold_o;
    logic       if_id_stall_o;
    logic       if_id_flush_o;
    logic       id_ex_stall_o;
    logic       id_ex_flush_o;

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i, id_rs2_use_i,
        output ex_rd_addr_i, ex_rd_we_i, ex_is_load_i, ex_jump_i,
        output ex_mdiv_start_i, mdiv_done_i,
        input  pc_hold_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o
    );

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_rs1_use_i, id_rs2_use_i,
        input  ex_rd_addr_i, ex_rd_we_i, ex_is_load_i, ex_jump_i,
        input  ex_mdiv_start_i, mdiv_done_i,
        output pc_hold_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencing for IF/ID, ID/EX and PC (load-use, mul/div, redirect)
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT         = 1,
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MDIV_TIMEOUT     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pipe_hazard_ctrl_if.slave        hz,
    output logic [1:0]               ctrl_state_o,
    output logic                     err_timeout_o,
    output logic [31:0]              stall_cnt_o
);
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_MDIV     = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);
    localparam logic [2:0] RD_RELOAD = 3'(REDIRECT_BUBBLES - 1);
    localparam logic [7:0] MDIV_TO   = 8'(MDIV_TIMEOUT);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  mcnt_q, mcnt_d;
    logic        err_q, err_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        pc_hold, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        lu_haz;

    assign lu_haz = hz.ex_is_load_i & hz.ex_rd_we_i & (hz.ex_rd_addr_i != 5'd0) &
                    ((hz.id_rs1_use_i & (hz.id_rs1_addr_i == hz.ex_rd_addr_i)) |
                     (hz.id_rs2_use_i & (hz.id_rs2_addr_i == hz.ex_rd_addr_i)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcnt_d      = mcnt_q;
        err_d       = err_q;
        pc_hold     = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        case (state_q)
            S_RUN: begin
                if (hz.ex_jump_i) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (REDIRECT_BUBBLES > 1) begin
                        state_d = S_REDIRECT;
                        cnt_d   = RD_RELOAD;
                    end
                end else if (hz.ex_mdiv_start_i && !hz.mdiv_done_i) begin
                    pc_hold     = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    state_d     = S_MDIV;
                    mcnt_d      = 8'd1;
                end else if (!hz.ex_mdiv_start_i && lu_haz) begin
                    pc_hold     = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d = S_LU_STALL;
                        cnt_d   = LU_RELOAD;
                    end
                end
            end
            S_LU_STALL: begin
                // EX holds a bubble here, so a redirect cannot originate from it
                pc_hold     = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_MDIV: begin
                if (hz.mdiv_done_i) begin
                    state_d = S_RUN;
                    mcnt_d  = 8'd0;
                end else if (mcnt_q == MDIV_TO) begin
                    err_d   = 1'b1;
                    state_d = S_RUN;
                    mcnt_d  = 8'd0;
                end else begin
                    pc_hold     = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                    mcnt_d      = mcnt_q + 8'd1;
                end
            end
            S_REDIRECT: begin
                if_id_flush = 1'b1;
                if (hz.ex_jump_i) begin
                    id_ex_flush = 1'b1;
                    cnt_d       = RD_RELOAD;
                end else if (cnt_q <= 3'd1) begin
                    state_d = S_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_RUN;
        endcase
        stall_cnt_d = (pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            cnt_q       <= 3'd0;
            mcnt_q      <= 8'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcnt_q      <= mcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Gate with rst_n so the pipeline sees no stall/flush while reset is held
    assign hz.pc_hold_o     = pc_hold & rst_n;
    assign hz.if_id_stall_o = if_id_stall & rst_n;
    assign hz.if_id_flush_o = if_id_flush & rst_n;
    assign hz.id_ex_stall_o = id_ex_stall & rst_n;
    assign hz.id_ex_flush_o = id_ex_flush & rst_n;
    assign ctrl_state_o     = state_q;
    assign err_timeout_o    = err_q;
    assign stall_cnt_o      = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl (two parameterisations)
module tb_pipe_hazard_ctrl;
    localparam logic [31:0] C_LU = 32'b11001;
    localparam logic [31:0] C_MD = 32'b11010;
    localparam logic [31:0] C_JP = 32'b00101;
    localparam logic [31:0] C_RD = 32'b00100;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] rs1, rs2, rd;
    logic rs1_use, rs2_use, rd_we, is_load, jump, mdiv_start, mdiv_done;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz_a ();
    pipe_hazard_ctrl_if hz_b ();
    logic [1:0]  state_a, state_b;
    logic        err_a, err_b;
    logic [31:0] scnt_a, scnt_b;

    assign hz_a.id_rs1_addr_i = rs1;       assign hz_b.id_rs1_addr_i = rs1;
    assign hz_a.id_rs2_addr_i = rs2;       assign hz_b.id_rs2_addr_i = rs2;
    assign hz_a.id_rs1_use_i  = rs1_use;   assign hz_b.id_rs1_use_i  = rs1_use;
    assign hz_a.id_rs2_use_i  = rs2_use;   assign hz_b.id_rs2_use_i  = rs2_use;
    assign hz_a.ex_rd_addr_i  = rd;        assign hz_b.ex_rd_addr_i  = rd;
    assign hz_a.ex_rd_we_i    = rd_we;     assign hz_b.ex_rd_we_i    = rd_we;
    assign hz_a.ex_is_load_i  = is_load;   assign hz_b.ex_is_load_i  = is_load;
    assign hz_a.ex_jump_i     = jump;      assign hz_b.ex_jump_i     = jump;
    assign hz_a.ex_mdiv_start_i = mdiv_start; assign hz_b.ex_mdiv_start_i = mdiv_start;
    assign hz_a.mdiv_done_i   = mdiv_done; assign hz_b.mdiv_done_i   = mdiv_done;

    pipe_hazard_ctrl #(.LOAD_LAT(1), .REDIRECT_BUBBLES(1), .MDIV_TIMEOUT(64)) u_a (
        .clk(clk), .rst_n(rst_n), .hz(hz_a),
        .ctrl_state_o(state_a), .err_timeout_o(err_a), .stall_cnt_o(scnt_a)
    );
    pipe_hazard_ctrl #(.LOAD_LAT(3), .REDIRECT_BUBBLES(3), .MDIV_TIMEOUT(8)) u_b (
        .clk(clk), .rst_n(rst_n), .hz(hz_b),
        .ctrl_state_o(state_b), .err_timeout_o(err_b), .stall_cnt_o(scnt_b)
    );

    logic [31:0] ctl_a, ctl_b;
    assign ctl_a = {27'd0, hz_a.pc_hold_o, hz_a.if_id_stall_o, hz_a.if_id_flush_o,
                    hz_a.id_ex_stall_o, hz_a.id_ex_flush_o};
    assign ctl_b = {27'd0, hz_b.pc_hold_o, hz_b.if_id_stall_o, hz_b.if_id_flush_o,
                    hz_b.id_ex_stall_o, hz_b.id_ex_flush_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        rs1_use = 1'b0; rs2_use = 1'b0; rd_we = 1'b0; is_load = 1'b0;
        jump = 1'b0; mdiv_start = 1'b0; mdiv_done = 1'b0;
    endtask

    initial begin
        clr();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl_a", ctl_a, 0);
        chk("rst_state_b", {30'd0, state_b}, 0);
        chk("rst_scnt_a", scnt_a, 0);
        rst_n = 1'b1;

        // idle after reset release
        for (int i = 0; i < 5; i++) begin
            #4;
            chk("idle_ctl_a", ctl_a, 0);
            chk("idle_ctl_b", ctl_b, 0);
            nxt();
        end
        chk("idle_state_a", {30'd0, state_a}, 0);
        chk("idle_scnt_b", scnt_b, 0);

        // load x5 in EX, ID reads rs2=x5
        is_load = 1'b1; rd_we = 1'b1; rd = 5'd5;
        rs1 = 5'd3; rs1_use = 1'b1; rs2 = 5'd5; rs2_use = 1'b1;
        #4;
        chk("lu_ctl_a", ctl_a, C_LU);
        chk("lu_ctl_b", ctl_b, C_LU);
        nxt(); clr();
        jump = 1'b1;
        #4;
        chk("lu_after_ctl_a", ctl_a, C_JP);
        chk("lu_after_state_a", {30'd0, state_a}, 0);
        chk("lu_after_scnt_a", scnt_a, 1);
        chk("lu_b_state1", {30'd0, state_b}, 1);
        chk("lu_b_ignores_jump", ctl_b, C_LU);
        nxt(); clr();
        #4;
        chk("lu_b_cycle3", ctl_b, C_LU);
        nxt();
        #4;
        chk("lu_b_done_ctl", ctl_b, 0);
        chk("lu_b_done_state", {30'd0, state_b}, 0);
        chk("lu_b_scnt", scnt_b, 3);

        // x0 as rd never stalls; unused source never stalls
        is_load = 1'b1; rd_we = 1'b1; rd = 5'd0;
        rs1 = 5'd0; rs1_use = 1'b1; rs2 = 5'd0; rs2_use = 1'b1;
        #4;
        chk("lu_x0_ctl_a", ctl_a, 0);
        chk("lu_x0_ctl_b", ctl_b, 0);
        nxt();
        rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7; rs1_use = 1'b0; rs2_use = 1'b0;
        #4;
        chk("lu_nouse_ctl_a", ctl_a, 0);
        nxt(); clr();

        // single-cycle mul/div result: no stall
        mdiv_start = 1'b1; mdiv_done = 1'b1;
        #4;
        chk("md1_ctl_a", ctl_a, 0);
        nxt(); clr();
        #4;
        chk("md1_state_a", {30'd0, state_a}, 0);

        // mdiv with done 6 cycles after start
        mdiv_start = 1'b1;
        #4;
        chk("md_start_ctl_a", ctl_a, C_MD);
        chk("md_start_ctl_b", ctl_b, C_MD);
        nxt(); clr();
        for (int i = 1; i < 6; i++) begin
            #4;
            chk("md_wait_ctl_a", ctl_a, C_MD);
            chk("md_wait_state_b", {30'd0, state_b}, 2);
            nxt();
        end
        mdiv_done = 1'b1;
        #4;
        chk("md_done_ctl_a", ctl_a, 0);
        chk("md_done_ctl_b", ctl_b, 0);
        chk("md_done_state_a", {30'd0, state_a}, 2);
        nxt(); clr();
        #4;
        chk("md_end_state_a", {30'd0, state_a}, 0);
        chk("md_end_scnt_a", scnt_a, 7);
        chk("md_end_scnt_b", scnt_b, 9);
        chk("md_end_err_b", {31'd0, err_b}, 0);
        nxt();

        // timeout on u_b (MDIV_TIMEOUT=8); u_a keeps waiting
        mdiv_start = 1'b1;
        #4;
        chk("to_start_ctl_b", ctl_b, C_MD);
        nxt(); clr();
        for (int i = 1; i < 8; i++) begin
            #4;
            chk("to_wait_ctl_b", ctl_b, C_MD);
            nxt();
        end
        #4;
        chk("to_release_ctl_b", ctl_b, 0);
        chk("to_release_ctl_a", ctl_a, C_MD);
        chk("to_release_err_pre", {31'd0, err_b}, 0);
        nxt();
        mdiv_done = 1'b1;
        #4;
        chk("to_err_b", {31'd0, err_b}, 1);
        chk("to_state_b", {30'd0, state_b}, 0);
        chk("to_done_ignored_b", ctl_b, 0);
        chk("to_a_release", ctl_a, 0);
        nxt(); clr();
        repeat (20) nxt();
        chk("to_err_sticky_b", {31'd0, err_b}, 1);
        chk("to_err_a", {31'd0, err_a}, 0);
        chk("to_scnt_a", scnt_a, 16);
        chk("to_scnt_b", scnt_b, 17);

        // jump with load-use and mdiv start: only flushes
        jump = 1'b1; mdiv_start = 1'b1;
        is_load = 1'b1; rd_we = 1'b1; rd = 5'd9; rs1 = 5'd9; rs1_use = 1'b1;
        #4;
        chk("jp_ctl_a", ctl_a, C_JP);
        chk("jp_ctl_b", ctl_b, C_JP);
        nxt(); clr();
        #4;
        chk("jp_a_after", ctl_a, 0);
        chk("jp_b_rd1", ctl_b, C_RD);
        chk("jp_b_state", {30'd0, state_b}, 3);
        nxt();
        #4;
        chk("jp_b_rd2", ctl_b, C_RD);
        nxt();
        #4;
        chk("jp_b_end", ctl_b, 0);
        chk("jp_b_end_state", {30'd0, state_b}, 0);
        chk("jp_scnt_b", scnt_b, 17);

        // jump again while in REDIRECT reloads the counter
        jump = 1'b1;
        #4;
        nxt();
        #4;
        chk("rj_ctl_b", ctl_b, C_JP);
        nxt(); clr();
        #4;
        chk("rj_rd1", ctl_b, C_RD);
        nxt();
        #4;
        chk("rj_rd2", ctl_b, C_RD);
        nxt();
        #4;
        chk("rj_end", ctl_b, 0);
        nxt();

        // reset in the 3rd MDIV cycle
        mdiv_start = 1'b1;
        #4;
        nxt(); clr();
        nxt();
        #2;
        chk("rm_pre_ctl_b", ctl_b, C_MD);
        rst_n = 1'b0;
        #1;
        chk("rm_ctl_a", ctl_a, 0);
        chk("rm_ctl_b", ctl_b, 0);
        chk("rm_state_a", {30'd0, state_a}, 0);
        chk("rm_state_b", {30'd0, state_b}, 0);
        chk("rm_scnt_b", scnt_b, 0);
        chk("rm_err_b", {31'd0, err_b}, 0);
        nxt();
        rst_n = 1'b1;
        #4;
        chk("rm_post_ctl_b", ctl_b, 0);
        chk("rm_post_state_b", {30'd0, state_b}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
